ads868x_scan_ctrl: RTL and testbench

ADS868X_SCAN_CTRL -- requirements
Module: ads868x_scan_ctrl

---
 rtl/ads868x_scan_pkg.sv | 26 ++
 rtl/ads868x_scan_timer.sv | 22 ++
 rtl/ads868x_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_ads868x_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ads868x_scan_pkg.sv
// Shared types and constants for the ADS868x multiplexed-channel scan controller.
package ads868x_scan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      SETTLE,
      CONVERT,
      STORE,
      DONE
   } state_t;

   localparam int unsigned CH_W        = 3;
   localparam int unsigned MAX_CH      = 8;
   localparam int unsigned TMR_W       = 16;
   localparam int unsigned TIMEOUT_CYC = 4096;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic logic [CH_W-1:0] lowest_set(input logic [MAX_CH-1:0] m);
      lowest_set = '0;
      for (int i = MAX_CH - 1; i >= 0; i--) begin
         if (m[i]) lowest_set = CH_W'(i);
      end
   endfunction

endpackage

// File: rtl/ads868x_scan_timer.sv
// Loadable down-counter shared by the mux settle delay and the conversion watchdog.
module ads868x_scan_timer
   import ads868x_scan_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   output logic             zero_c
);

   logic [TMR_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)                cnt <= '0;
      else if (load)          cnt <= load_val;
      else if (cnt != '0)     cnt <= cnt - TMR_W'(1);
   end

   assign zero_c = (cnt == '0);

endmodule

// File: rtl/ads868x_scan_ctrl.sv
// Scans the masked mux channels, requesting one ADC conversion per channel.
// Define ADS868X_SCAN_TIMEOUT_EN to add a CONVERT watchdog that skips a silent channel and sets err.
module ads868x_scan_ctrl
   import ads868x_scan_pkg::*;
#(
   parameter int unsigned NUM_CH     = 8,
   parameter int unsigned SETTLE_CYC = 200,
   parameter int unsigned DATA_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_mask,
   output logic              busy,
   output logic [CH_W-1:0]   ch_sel,
   output logic              mux_en,
   output logic              conv_req,
   input  logic              conv_ack,
   input  logic [DATA_W-1:0] conv_data,
   output logic              res_valid,
   output logic [CH_W-1:0]   res_ch,
   output logic [DATA_W-1:0] res_data,
   output logic              done,
   output logic              err
);

   state_t             state;
   logic [MAX_CH-1:0]  pend;
   logic [MAX_CH-1:0]  pend_left_c;
   logic [DATA_W-1:0]  cap;
   logic               tmr_load;
   logic               tmr_zero;
   logic [TMR_W-1:0]   tmr_val;

   // Remaining channels once the current one is retired.
   assign pend_left_c = pend & ~(MAX_CH'(1) << ch_sel);

   // Settle count loads in SELECT; watchdog count loads on entry to CONVERT.
   assign tmr_load = (state == SELECT) || ((state == SETTLE) && tmr_zero);
   assign tmr_val  = (state == SELECT) ? TMR_W'(SETTLE_CYC - 1) : TMR_W'(TIMEOUT_CYC - 1);

   ads868x_scan_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero_c   (tmr_zero)
   );

`ifdef ADS868X_SCAN_TIMEOUT_EN
   logic err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend      <= '0;
         cap       <= '0;
         busy      <= 1'b0;
         ch_sel    <= '0;
         mux_en    <= 1'b0;
         conv_req  <= 1'b0;
         res_valid <= 1'b0;
         res_ch    <= '0;
         res_data  <= '0;
         done      <= 1'b0;
`ifdef ADS868X_SCAN_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         res_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pend  <= MAX_CH'(ch_mask);
                  busy  <= 1'b1;
                  state <= (ch_mask == '0) ? DONE : SELECT;
               end
            end
            SELECT: begin
               ch_sel <= lowest_set(pend);
               mux_en <= 1'b1;
               state  <= SETTLE;
            end
            SETTLE: begin
               if (tmr_zero) state <= CONVERT;
            end
            CONVERT: begin
               // An ack only counts once the request is visible to the SPI master.
               if (conv_req && conv_ack) begin
                  cap      <= conv_data;
                  conv_req <= 1'b0;
                  state    <= STORE;
               end
`ifdef ADS868X_SCAN_TIMEOUT_EN
               else if (tmr_zero) begin
                  err_q    <= 1'b1;
                  conv_req <= 1'b0;
                  pend     <= pend_left_c;
                  state    <= (pend_left_c == '0) ? DONE : SELECT;
               end
`endif
               else begin
                  conv_req <= 1'b1;
               end
            end
            STORE: begin
               res_valid <= 1'b1;
               res_ch    <= ch_sel;
               res_data  <= cap;
               pend      <= pend_left_c;
               state     <= (pend_left_c == '0) ? DONE : SELECT;
            end
            DONE: begin
               done   <= 1'b1;
               busy   <= 1'b0;
               mux_en <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ads868x_scan_ctrl.sv
// Bench for ads868x_scan_ctrl: two instances (settle 4 and settle 1) checked every cycle
// against a timeline model of the scan; ADS868X_SCAN_TIMEOUT_EN enables the watchdog scenario.
module tb_ads868x_scan_ctrl;

   localparam int unsigned DW = 16;
   localparam int unsigned S0 = 4;
   localparam int unsigned S1 = 1;
   localparam int unsigned TO = 4096;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst[2], start[2], ack[2];
   logic [7:0]    mask[2];
   logic [DW-1:0] cdata[2];
   logic          busy[2], mux_en[2], conv_req[2], res_valid[2], done[2], err[2];
   logic [2:0]    ch_sel[2], res_ch[2];
   logic [DW-1:0] res_data[2];

   logic          e_busy[2], e_mux_en[2], e_conv_req[2], e_res_valid[2], e_done[2], e_err[2];
   logic [2:0]    e_ch_sel[2], e_res_ch[2];
   logic [DW-1:0] e_res_data[2];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;
   bit noise[2];
   int t0[2], n_rv[2], n_done[2], n_req_hi[2], first_req[2], first_done[2];
   logic [28:0] got_v, exp_v;

   ads868x_scan_ctrl #(.NUM_CH(8), .SETTLE_CYC(S0), .DATA_W(DW)) u0 (
      .clk(clk), .rst(rst[0]), .start(start[0]), .ch_mask(mask[0]), .busy(busy[0]),
      .ch_sel(ch_sel[0]), .mux_en(mux_en[0]), .conv_req(conv_req[0]), .conv_ack(ack[0]),
      .conv_data(cdata[0]), .res_valid(res_valid[0]), .res_ch(res_ch[0]),
      .res_data(res_data[0]), .done(done[0]), .err(err[0]));

   ads868x_scan_ctrl #(.NUM_CH(8), .SETTLE_CYC(S1), .DATA_W(DW)) u1 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .ch_mask(mask[1]), .busy(busy[1]),
      .ch_sel(ch_sel[1]), .mux_en(mux_en[1]), .conv_req(conv_req[1]), .conv_ack(ack[1]),
      .conv_data(cdata[1]), .res_valid(res_valid[1]), .res_ch(res_ch[1]),
      .res_data(res_data[1]), .done(done[1]), .err(err[1]));

   always @(posedge clk) cyc <= cyc + 1;

   // Every-cycle comparison of both instances against the model, plus event counters.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            got_v = {busy[d], ch_sel[d], mux_en[d], conv_req[d], res_valid[d],
                     res_ch[d], res_data[d], done[d], err[d]};
            exp_v = {e_busy[d], e_ch_sel[d], e_mux_en[d], e_conv_req[d], e_res_valid[d],
                     e_res_ch[d], e_res_data[d], e_done[d], e_err[d]};
            n_assert++;
            if (got_v !== exp_v) begin
               n_fail++;
               $display("FAIL outputs dut%0d cyc=%0d got=%h exp=%h", d, cyc, got_v, exp_v);
            end
            if (res_valid[d] === 1'b1) n_rv[d]++;
            if (done[d] === 1'b1) begin
               n_done[d]++;
               if (first_done[d] < 0) first_done[d] = cyc - t0[d];
            end
            if (conv_req[d] === 1'b1) begin
               n_req_hi[d]++;
               if (first_req[d] < 0) first_req[d] = cyc - t0[d];
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_assert++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic clr_exp(input int d);
      e_busy[d] = 0; e_mux_en[d] = 0; e_conv_req[d] = 0; e_res_valid[d] = 0;
      e_done[d] = 0; e_err[d] = 0; e_ch_sel[d] = '0; e_res_ch[d] = '0; e_res_data[d] = '0;
   endtask

   // One clock; during a noisy scan, start and mask are randomised (must be ignored).
   task automatic step(input int d);
      @(posedge clk);
      #1;
      if (noise[d]) begin
         start[d] = 1'($urandom_range(0, 1));
         mask[d]  = 8'($urandom);
      end
   endtask

   task automatic idle(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         ack[d]   = 1'($urandom_range(0, 1));
         cdata[d] = DW'($urandom);
         step(d);
      end
      ack[d] = 1'b0;
   endtask

   task automatic clear_counts(input int d);
      n_rv[d] = 0; n_done[d] = 0; n_req_hi[d] = 0; first_req[d] = -1; first_done[d] = -1;
      t0[d] = cyc;
   endtask

   // Timeline model of one scan started in the current cycle (cycle 0).
   task automatic do_scan(input int d, input logic [7:0] m, input bit rnd_dly,
                          input bit nz, input int abort_ch, input int to_ch);
      int s;
      int dly;
      logic [DW-1:0] dv;
      s = (d == 0) ? int'(S0) : int'(S1);
      clear_counts(d);
      start[d] = 1'b1;
      mask[d]  = m;
      noise[d] = nz;
      step(d);
      start[d] = 1'b0;
      e_busy[d] = 1'b1;
      if (m == 8'h00) begin
         noise[d] = 1'b0;
         step(d);
         start[d] = 1'b0;
         e_done[d] = 1'b1; e_busy[d] = 1'b0;
         step(d);
         e_done[d] = 1'b0;
         return;
      end
      for (int ch = 0; ch < 8; ch++) begin
         if (m[ch]) begin
            step(d);
            e_ch_sel[d] = 3'(ch); e_mux_en[d] = 1'b1; e_res_valid[d] = 1'b0;
            if (ch == abort_ch) begin
               noise[d] = 1'b0; start[d] = 1'b0; rst[d] = 1'b1;
               step(d);
               rst[d] = 1'b0;
               clr_exp(d);
               return;
            end
            for (int i = 0; i < s; i++) begin
               ack[d]   = 1'($urandom_range(0, 1));
               cdata[d] = DW'($urandom);
               step(d);
            end
            ack[d] = 1'b0;
            step(d);
            e_conv_req[d] = 1'b1;
            if (ch == to_ch) begin
               repeat (TO - 1) step(d);
               e_conv_req[d] = 1'b0; e_err[d] = 1'b1;
            end else begin
               dly = rnd_dly ? int'($urandom_range(0, 5)) : 0;
               repeat (dly) step(d);
               dv = DW'($urandom);
               ack[d] = 1'b1; cdata[d] = dv;
               step(d);
               ack[d] = 1'b0;
               e_conv_req[d] = 1'b0;
               step(d);
               e_res_valid[d] = 1'b1; e_res_ch[d] = 3'(ch); e_res_data[d] = dv;
            end
         end
      end
      noise[d] = 1'b0;
      step(d);
      start[d] = 1'b0;
      e_res_valid[d] = 1'b0; e_done[d] = 1'b1; e_busy[d] = 1'b0; e_mux_en[d] = 1'b0;
      step(d);
      e_done[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; start[d] = 1'b0; ack[d] = 1'b0; mask[d] = '0; cdata[d] = '0;
         noise[d] = 1'b0;
         clr_exp(d);
         clear_counts(d);
      end
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      rst[0] = 1'b0; rst[1] = 1'b0;
      idle(0, 3);

      // Mask 0x05: channels 0 then 2.
      do_scan(0, 8'h05, 1'b1, 1'b0, -1, -1);
      chk("req_latency", first_req[0], 3 + int'(S0));
      chk("rv_count_05", n_rv[0], 2);
      chk("done_count_05", n_done[0], 1);
      idle(0, 4);

      // Empty mask: done two cycles after start, no request.
      do_scan(0, 8'h00, 1'b0, 1'b0, -1, -1);
      chk("zero_done_lat", first_done[0], 2);
      chk("zero_no_req", n_req_hi[0], 0);
      chk("zero_done_count", n_done[0], 1);
      idle(0, 3);

      // Repeated start during the scan is ignored.
      do_scan(0, 8'h05, 1'b1, 1'b1, -1, -1);
      chk("restart_rv", n_rv[0], 2);
      chk("restart_done", n_done[0], 1);
      idle(0, 3);

      // Reset while channel 1 settles; then a fresh scan.
      do_scan(0, 8'h03, 1'b1, 1'b0, 1, -1);
      idle(0, 5);
      chk("abort_no_done", n_done[0], 0);
      chk("abort_rv", n_rv[0], 1);
      do_scan(0, 8'h82, 1'b1, 1'b0, -1, -1);
      chk("post_abort_rv", n_rv[0], 2);
      idle(0, 3);

      // Settle of one cycle, ack in the very cycle the request rises.
      do_scan(1, 8'h01, 1'b0, 1'b0, -1, -1);
      chk("s1_req_latency", first_req[1], 4);
      chk("s1_req_width", n_req_hi[1], 1);
      chk("s1_rv", n_rv[1], 1);
      idle(1, 3);

      // Randomised scans on both instances.
      for (int k = 0; k < 10; k++) begin
         logic [7:0] m;
         int d;
         m = 8'($urandom);
         d = k % 2;
         do_scan(d, m, 1'b1, bit'($urandom_range(0, 1)), -1, -1);
         chk("rand_rv", n_rv[d], $countones(m));
         chk("rand_done", n_done[d], 1);
         idle(d, int'($urandom_range(1, 4)));
      end

`ifdef ADS868X_SCAN_TIMEOUT_EN
      // Channel 3 never acks: watchdog skips it, channel 4 still delivered.
      do_scan(0, 8'h18, 1'b1, 1'b0, -1, 3);
      chk("to_rv", n_rv[0], 1);
      chk("to_done", n_done[0], 1);
      chk("to_err", int'(err[0]), 1);
      idle(0, 3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
